wb_fifo_master: RTL and testbench
=================================

// Module: wb_fifo_master
// PURPOSE
//  Command-FIFO-driven Wishbone master: the initiator counterpart to our FIFO-backed WB slave devices.
//  Pops command words from a show-ahead command FIFO, issues one single (non-burst) WB classic cycle per
//  command, pushes read data into a response FIFO. Sits between a host/link FIFO pair and the WB fabric.
// PARAMETERS
//  TIMEOUT   256            cycles a WB cycle may stay un-terminated before forced error; 0 = no timeout
//  ERR_WORD  32'hdeadbeef   word pushed to response FIFO when a read ends in error/timeout
// PORTS
//  wb_clk      in   1   clock
//  wb_reset    in   1   asynchronous, active-high reset
//  soft_rst    in   1   synchronous abort: return to IDLE, drop bus cycle, keep err_flag
//  cf_d        in   32  command FIFO head word (show-ahead, valid while cf_rdempty=0)
//  cf_rdempty  in   1   command FIFO empty
//  cf_rd       out  1   command FIFO pop, 1-cycle pulse per consumed word
//  rf_d        out  32  response FIFO write data
//  rf_wr       out  1   response FIFO write strobe, 1 cycle
//  rf_wrfull   in   1   response FIFO full
//  m_adr       out  32  WB address
//  m_dat_o     out  32  WB write data
//  m_dat_i     in   32  WB read data
//  m_sel       out  4   WB byte lanes
//  m_we        out  1   WB write enable
//  m_cyc       out  1   WB cycle
//  m_stb       out  1   WB strobe
//  m_ack       in   1   WB ack
//  m_err       in   1   WB error
//  m_rty       in   1   WB retry
//  busy        out  1   1 whenever state != IDLE
//  err_flag    out  1   sticky: set on m_err or timeout; cleared only by err_clr or wb_reset
//  err_clr     in   1   clears err_flag (set wins if same cycle)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0. soft_rst: same except err_flag retained.
//  Command: word0 header {we[31], 3'b0, sel[27:24], 24'b0}; word1 address; word2 data (writes only).
//  cf_rd = combinational: 1 in IDLE/ADR/DAT when cf_rdempty=0; word captured on that edge.
//  FSM: IDLE -(pop hdr)-> ADR -(pop adr)-> we ? DAT : RSV.
//   DAT -(pop data)-> BUS.  RSV: wait rf_wrfull=0 (reserves response slot) -> BUS.
//   BUS: registered m_cyc=m_stb=1, m_adr/m_sel/m_we/m_dat_o stable for the whole cycle.
//    m_ack: capture m_dat_i; read -> RESP, write -> IDLE.  m_err (priority over ack) or timeout:
//    set err_flag; read -> RESP with ERR_WORD, write -> IDLE.  m_rty: RTY (cyc/stb low 1 cycle) -> BUS.
//   RESP: rf_wr=1 one cycle, rf_d=captured word -> IDLE.
//  m_cyc/m_stb drop the cycle after the terminating edge; min gap 1 cycle between bus cycles.
//  Timeout counter: width clog2(TIMEOUT+1), cleared entering BUS from DAT/RSV, NOT cleared on RTY;
//   timeout fires when count reaches TIMEOUT while in BUS/RTY (ack on that same edge wins).
//  Waiting states (ADR/DAT/RSV) block indefinitely; no partial-command timeout.
//  Latency: read with all FIFOs ready, zero-wait slave: hdr pop T0, adr pop T1, RSV T2, stb T3,
//   ack T3, rf_wr T4. Write: stb asserted cycle after data pop.
//  soft_rst mid-BUS: m_cyc/m_stb low next cycle, no rf_wr, partially popped command discarded.
//  wb_reset mid-operation: immediate async clear of all outputs.
// TESTING
//  1 Write hdr 32'h8F000000, adr 0x10, data 0xA5A5A5A5, slave acks 1st cycle -> one WB write, sel=F, no rf_wr.
//  2 Read hdr 0x0F000000, adr 0x04, slave returns 0x1234ABCD after 3 waits -> rf_d=0x1234ABCD, 1 rf_wr.
//  3 Read with rf_wrfull=1 for 10 cycles -> m_stb stays 0 until rf_wrfull drops, then normal read.
//  4 Read, slave never acks, TIMEOUT=16 -> cycle ends after 16 cycles, rf_d=0xdeadbeef, err_flag=1.
//  5 Slave m_rty twice then ack -> two 1-cycle stb gaps, single response, err_flag unchanged.
//  6 soft_rst during BUS and cf empty mid-command -> cyc low next cycle, IDLE, next command correct.

Source files
------------

// File: rtl/wb_fifo_master.sv
// Command-FIFO-driven Wishbone classic master: one single WB cycle per command,
// read data (or ERR_WORD on error/timeout) pushed to a response FIFO.
module wb_fifo_master #(
    parameter int unsigned TIMEOUT  = 256,
    parameter logic [31:0] ERR_WORD = 32'hdeadbeef
) (
    input  logic        wb_clk,
    input  logic        wb_reset,
    input  logic        soft_rst,
    input  logic [31:0] cf_d,
    input  logic        cf_rdempty,
    output logic        cf_rd,
    output logic [31:0] rf_d,
    output logic        rf_wr,
    input  logic        rf_wrfull,
    output logic [31:0] m_adr,
    output logic [31:0] m_dat_o,
    input  logic [31:0] m_dat_i,
    output logic [3:0]  m_sel,
    output logic        m_we,
    output logic        m_cyc,
    output logic        m_stb,
    input  logic        m_ack,
    input  logic        m_err,
    input  logic        m_rty,
    output logic        busy,
    output logic        err_flag,
    input  logic        err_clr
);

    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADR  = 3'd1,
        DAT  = 3'd2,
        RSV  = 3'd3,
        BUS  = 3'd4,
        RTY  = 3'd5,
        RESP = 3'd6
    } state_t;

    state_t             state_reg;
    logic               we_reg;
    logic [3:0]         sel_reg;
    logic [31:0]        adr_reg;
    logic [31:0]        dat_reg;
    logic [31:0]        rdat_reg;
    logic               rf_wr_reg;
    logic               bus_reg;
    logic               err_flag_reg;
    logic [CNT_W-1:0]   tmo_cnt_reg;
    logic               timeout_hit;
    logic               in_fetch;

    // Fires on the edge at which the counter reaches TIMEOUT, so the bus
    // cycle (including retry gaps) lasts at most TIMEOUT clocks.
    generate
        if (TIMEOUT > 0) begin : g_tmo
            assign timeout_hit = ((state_reg == BUS) || (state_reg == RTY)) &&
                                 (tmo_cnt_reg == CNT_W'(TIMEOUT - 1));
        end else begin : g_no_tmo
            assign timeout_hit = 1'b0;
        end
    endgenerate

    assign in_fetch = (state_reg == IDLE) || (state_reg == ADR) || (state_reg == DAT);
    // A word is never popped while a reset is pending, so no command word is lost to it.
    assign cf_rd    = in_fetch && !cf_rdempty && !soft_rst && !wb_reset;

    assign rf_d     = rdat_reg;
    assign rf_wr    = rf_wr_reg;
    assign m_adr    = adr_reg;
    assign m_dat_o  = dat_reg;
    assign m_sel    = sel_reg;
    assign m_we     = we_reg;
    assign m_cyc    = bus_reg;
    assign m_stb    = bus_reg;
    assign busy     = (state_reg != IDLE);
    assign err_flag = err_flag_reg;

    always_ff @(posedge wb_clk or posedge wb_reset) begin
        if (wb_reset) begin
            state_reg    <= IDLE;
            we_reg       <= 1'b0;
            sel_reg      <= 4'h0;
            adr_reg      <= 32'h0;
            dat_reg      <= 32'h0;
            rdat_reg     <= 32'h0;
            rf_wr_reg    <= 1'b0;
            bus_reg      <= 1'b0;
            err_flag_reg <= 1'b0;
            tmo_cnt_reg  <= '0;
        end else if (soft_rst) begin
            state_reg    <= IDLE;
            we_reg       <= 1'b0;
            sel_reg      <= 4'h0;
            adr_reg      <= 32'h0;
            dat_reg      <= 32'h0;
            rdat_reg     <= 32'h0;
            rf_wr_reg    <= 1'b0;
            bus_reg      <= 1'b0;
            tmo_cnt_reg  <= '0;
            if (err_clr) begin
                err_flag_reg <= 1'b0;
            end
        end else begin
            rf_wr_reg <= 1'b0;
            if (err_clr) begin
                err_flag_reg <= 1'b0;
            end
            case (state_reg)
                IDLE: begin
                    if (cf_rd) begin
                        we_reg    <= cf_d[31];
                        sel_reg   <= cf_d[27:24];
                        state_reg <= ADR;
                    end
                end
                ADR: begin
                    if (cf_rd) begin
                        adr_reg   <= cf_d;
                        state_reg <= we_reg ? DAT : RSV;
                    end
                end
                DAT: begin
                    if (cf_rd) begin
                        dat_reg     <= cf_d;
                        bus_reg     <= 1'b1;
                        tmo_cnt_reg <= '0;
                        state_reg   <= BUS;
                    end
                end
                RSV: begin
                    // Holding here until there is room guarantees the RESP push never overflows.
                    if (!rf_wrfull) begin
                        bus_reg     <= 1'b1;
                        tmo_cnt_reg <= '0;
                        state_reg   <= BUS;
                    end
                end
                BUS: begin
                    tmo_cnt_reg <= tmo_cnt_reg + CNT_W'(1);
                    if (m_err || (timeout_hit && !m_ack)) begin
                        bus_reg      <= 1'b0;
                        err_flag_reg <= 1'b1;
                        if (we_reg) begin
                            state_reg <= IDLE;
                        end else begin
                            rdat_reg  <= ERR_WORD;
                            rf_wr_reg <= 1'b1;
                            state_reg <= RESP;
                        end
                    end else if (m_ack) begin
                        bus_reg <= 1'b0;
                        if (we_reg) begin
                            state_reg <= IDLE;
                        end else begin
                            rdat_reg  <= m_dat_i;
                            rf_wr_reg <= 1'b1;
                            state_reg <= RESP;
                        end
                    end else if (m_rty) begin
                        bus_reg   <= 1'b0;
                        state_reg <= RTY;
                    end
                end
                RTY: begin
                    tmo_cnt_reg <= tmo_cnt_reg + CNT_W'(1);
                    if (timeout_hit) begin
                        err_flag_reg <= 1'b1;
                        if (we_reg) begin
                            state_reg <= IDLE;
                        end else begin
                            rdat_reg  <= ERR_WORD;
                            rf_wr_reg <= 1'b1;
                            state_reg <= RESP;
                        end
                    end else begin
                        bus_reg   <= 1'b1;
                        state_reg <= BUS;
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_fifo_master.sv
// Bench for wb_fifo_master: queue-backed FIFO and WB slave models, table vectors,
// hand-written corner sequences and a randomized run against a transaction-level model.
module tb_wb_fifo_master;

    localparam logic [31:0] ERR_W = 32'hdeadbeef;

    logic        wb_clk;
    logic        wb_reset, soft_rst, err_clr;
    logic [31:0] cf_d;
    logic        cf_rdempty, cf_rd;
    logic [31:0] rf_d;
    logic        rf_wr, rf_wrfull;
    logic [31:0] m_adr, m_dat_o, m_dat_i;
    logic [3:0]  m_sel;
    logic        m_we, m_cyc, m_stb, m_ack, m_err, m_rty;
    logic        busy, err_flag;

    wb_fifo_master #(.TIMEOUT(16), .ERR_WORD(ERR_W)) dut (
        .wb_clk(wb_clk), .wb_reset(wb_reset), .soft_rst(soft_rst),
        .cf_d(cf_d), .cf_rdempty(cf_rdempty), .cf_rd(cf_rd),
        .rf_d(rf_d), .rf_wr(rf_wr), .rf_wrfull(rf_wrfull),
        .m_adr(m_adr), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_sel(m_sel),
        .m_we(m_we), .m_cyc(m_cyc), .m_stb(m_stb),
        .m_ack(m_ack), .m_err(m_err), .m_rty(m_rty),
        .busy(busy), .err_flag(err_flag), .err_clr(err_clr)
    );

    typedef struct packed {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
    } bus_t;

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        int          waits;
        int          rtys;
        logic        err;
        logic        never;
        logic [31:0] rdata;
        int          exp_rsp_n;
        logic [31:0] exp_rsp;
        logic        exp_errf;
        int          exp_strobes;
        int          exp_stb_cycles;
    } vec_t;

    int checks = 0;
    int failures = 0;

    logic [31:0] cmd_q[$];
    logic [31:0] rsp_q[$];
    bus_t        bus_q[$];
    bit          cf_stall;
    int          slv_waits, slv_rty_left;
    bit          slv_err, slv_never;
    logic [31:0] slv_rdata;
    int          strobes, stb_cycles;

    initial begin
        wb_clk = 1'b0;
        forever #5 wb_clk = ~wb_clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "watchdog");
    end

    // FIFO and slave environment: decide at the falling edge, act after the rising edge.
    initial begin : env
        int  wait_cnt;
        bit  prev_stb, pop_pending;
        wait_cnt = 0;
        prev_stb = 0;
        forever begin
            @(negedge wb_clk);
            if (rf_wr) rsp_q.push_back(rf_d);
            pop_pending = cf_rd;
            if (m_cyc && m_stb) begin
                stb_cycles++;
                if (!prev_stb) strobes++;
                if (!slv_never) begin
                    if (wait_cnt < slv_waits) begin
                        wait_cnt++;
                    end else if (slv_rty_left > 0) begin
                        m_rty = 1'b1;
                        slv_rty_left--;
                    end else begin
                        bus_q.push_back({m_we, m_sel, m_adr, m_dat_o});
                        if (slv_err) m_err = 1'b1;
                        else begin
                            m_ack   = 1'b1;
                            m_dat_i = slv_rdata;
                        end
                    end
                end
            end else begin
                wait_cnt = 0;
            end
            prev_stb = m_cyc && m_stb;
            @(posedge wb_clk);
            #2;
            m_ack = 1'b0;
            m_err = 1'b0;
            m_rty = 1'b0;
            if (pop_pending && cmd_q.size() > 0) void'(cmd_q.pop_front());
            cf_rdempty = (cmd_q.size() == 0) || cf_stall;
            cf_d       = (cmd_q.size() > 0) ? cmd_q[0] : 32'h0;
        end
    end

    task automatic tick();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_cmd(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                            input logic [31:0] dat);
        cmd_q.push_back({we, 3'b000, sel, 24'h0});
        cmd_q.push_back(adr);
        if (we) cmd_q.push_back(dat);
    endtask

    task automatic set_slave(input int waits, input int rtys, input bit err, input bit never,
                             input logic [31:0] rdata);
        slv_waits    = waits;
        slv_rty_left = rtys;
        slv_err      = err;
        slv_never    = never;
        slv_rdata    = rdata;
    endtask

    task automatic clear_logs();
        rsp_q.delete();
        bus_q.delete();
        strobes    = 0;
        stb_cycles = 0;
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        bit done;
        n = 0;
        done = 0;
        while (!done && n < 400) begin
            @(negedge wb_clk);
            n++;
            if (cmd_q.size() == 0 && !busy) done = 1;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s: still busy after %0d cycles, expected idle", name, n);
        end
        tick();
    endtask

    task automatic wait_stb(input string name);
        int n;
        n = 0;
        while (!m_stb && n < 50) begin
            @(negedge wb_clk);
            n++;
        end
        check(name, {31'h0, m_stb}, 32'h1);
    endtask

    task automatic check_bus(input string name, input logic we, input logic [3:0] sel,
                             input logic [31:0] adr, input logic [31:0] dat);
        bus_t b;
        check({name, " bus_n"}, bus_q.size(), 1);
        if (bus_q.size() > 0) begin
            b = bus_q[0];
            check({name, " adr"}, b.adr, adr);
            check({name, " sel"}, {28'h0, b.sel}, {28'h0, sel});
            check({name, " we"}, {31'h0, b.we}, {31'h0, we});
            if (we) check({name, " dat"}, b.dat, dat);
        end
    endtask

    vec_t vecs[7];

    initial begin : main
        logic [5:0]  rd_seq, stb_seq, wr_seq;
        logic [31:0] exp_rsp;
        logic        exp_err_acc;
        logic        r_we, r_err;
        logic [3:0]  r_sel;
        logic [31:0] r_adr, r_dat, r_rdata;
        int          r_waits, r_rtys;

        vecs[0] = '{1'b1, 4'hF, 32'h10, 32'hA5A5A5A5, 0, 0, 1'b0, 1'b0, 32'h0,        0, 32'h0,        1'b0, 1, 1};
        vecs[1] = '{1'b0, 4'hF, 32'h04, 32'h0,        3, 0, 1'b0, 1'b0, 32'h1234ABCD, 1, 32'h1234ABCD, 1'b0, 1, 4};
        vecs[2] = '{1'b0, 4'h3, 32'h20, 32'h0,        0, 2, 1'b0, 1'b0, 32'hCAFEF00D, 1, 32'hCAFEF00D, 1'b0, 3, 3};
        vecs[3] = '{1'b1, 4'h1, 32'h30, 32'h11,       0, 0, 1'b1, 1'b0, 32'h0,        0, 32'h0,        1'b1, 1, 1};
        vecs[4] = '{1'b0, 4'hF, 32'h08, 32'h0,        0, 0, 1'b0, 1'b1, 32'h0,        1, ERR_W,        1'b1, 1, 16};
        vecs[5] = '{1'b0, 4'h6, 32'h0C, 32'h0,        1, 0, 1'b1, 1'b0, 32'h77,       1, ERR_W,        1'b1, 1, 2};
        vecs[6] = '{1'b1, 4'hC, 32'h40, 32'h55AA,     2, 1, 1'b0, 1'b0, 32'h0,        0, 32'h0,        1'b0, 2, 6};

        wb_reset = 1'b1; soft_rst = 1'b0; err_clr = 1'b0; rf_wrfull = 1'b0;
        m_ack = 1'b0; m_err = 1'b0; m_rty = 1'b0; m_dat_i = 32'h0;
        cf_d = 32'h0; cf_rdempty = 1'b1; cf_stall = 1'b0;
        set_slave(0, 0, 0, 0, 32'h0);
        clear_logs();

        repeat (3) @(negedge wb_clk);
        check("reset ctrl", {24'h0, m_cyc, m_stb, cf_rd, rf_wr, busy, err_flag, m_we, 1'b0}, 32'h0);
        check("reset adr", m_adr, 32'h0);
        check("reset rf_d", rf_d, 32'h0);
        tick();
        wb_reset = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            pulse_err_clr();
            set_slave(vecs[i].waits, vecs[i].rtys, vecs[i].err, vecs[i].never, vecs[i].rdata);
            clear_logs();
            push_cmd(vecs[i].we, vecs[i].sel, vecs[i].adr, vecs[i].dat);
            wait_done($sformatf("v%0d done", i));
            $display("VEC %0d we=%0d adr=%h rsp_n=%0d strobes=%0d stb_cycles=%0d err_flag=%0d",
                     i, vecs[i].we, vecs[i].adr, rsp_q.size(), strobes, stb_cycles, err_flag);
            check($sformatf("v%0d rsp_n", i), rsp_q.size(), vecs[i].exp_rsp_n);
            if (vecs[i].exp_rsp_n > 0)
                check($sformatf("v%0d rsp", i), (rsp_q.size() > 0) ? rsp_q[0] : 32'hx, vecs[i].exp_rsp);
            check($sformatf("v%0d err_flag", i), {31'h0, err_flag}, {31'h0, vecs[i].exp_errf});
            check($sformatf("v%0d strobes", i), strobes, vecs[i].exp_strobes);
            check($sformatf("v%0d stb_cycles", i), stb_cycles, vecs[i].exp_stb_cycles);
            if (!vecs[i].never)
                check_bus($sformatf("v%0d", i), vecs[i].we, vecs[i].sel, vecs[i].adr, vecs[i].dat);
        end
        set_slave(0, 0, 0, 0, 32'h0);
        pulse_err_clr();
        check("err_clr", {31'h0, err_flag}, 32'h0);

        // Read latency with everything ready: pops T0/T1, strobe T3, response push T4.
        set_slave(0, 0, 0, 0, 32'h0BADCAFE);
        clear_logs();
        cf_stall = 1'b1;
        tick();
        push_cmd(1'b0, 4'hF, 32'h100, 32'h0);
        cf_stall = 1'b0;
        for (int t = 0; t < 6; t++) begin
            @(negedge wb_clk);
            rd_seq[t] = cf_rd; stb_seq[t] = m_stb; wr_seq[t] = rf_wr;
        end
        check("rdlat cf_rd", {26'h0, rd_seq}, 32'h03);
        check("rdlat stb", {26'h0, stb_seq}, 32'h08);
        check("rdlat rf_wr", {26'h0, wr_seq}, 32'h10);
        wait_done("rdlat done");
        check("rdlat rsp", (rsp_q.size() > 0) ? rsp_q[0] : 32'hx, 32'h0BADCAFE);

        // Write latency: strobe the cycle after the data pop, no response.
        clear_logs();
        cf_stall = 1'b1;
        tick();
        push_cmd(1'b1, 4'h9, 32'h104, 32'hFEEDFACE);
        cf_stall = 1'b0;
        for (int t = 0; t < 6; t++) begin
            @(negedge wb_clk);
            rd_seq[t] = cf_rd; stb_seq[t] = m_stb; wr_seq[t] = rf_wr;
        end
        check("wrlat cf_rd", {26'h0, rd_seq}, 32'h07);
        check("wrlat stb", {26'h0, stb_seq}, 32'h08);
        check("wrlat rf_wr", {26'h0, wr_seq}, 32'h00);
        wait_done("wrlat done");
        check_bus("wrlat", 1'b1, 4'h9, 32'h104, 32'hFEEDFACE);

        // Response FIFO full: no strobe until it drains.
        set_slave(0, 0, 0, 0, 32'h13572468);
        clear_logs();
        rf_wrfull = 1'b1;
        push_cmd(1'b0, 4'hF, 32'h200, 32'h0);
        repeat (10) tick();
        check("full stb_cycles", stb_cycles, 0);
        check("full busy", {31'h0, busy}, 32'h1);
        rf_wrfull = 1'b0;
        wait_done("full done");
        check("full rsp_n", rsp_q.size(), 1);
        check("full rsp", (rsp_q.size() > 0) ? rsp_q[0] : 32'hx, 32'h13572468);

        // soft_rst mid-bus keeps err_flag and drops the cycle.
        pulse_err_clr();
        set_slave(0, 0, 1, 0, 32'h0);
        push_cmd(1'b1, 4'hF, 32'h300, 32'h1);
        wait_done("srst err done");
        check("srst err before", {31'h0, err_flag}, 32'h1);
        set_slave(0, 0, 0, 1, 32'h0);
        clear_logs();
        push_cmd(1'b0, 4'hF, 32'h304, 32'h0);
        wait_stb("srst stb seen");
        tick();
        soft_rst = 1'b1;
        tick();
        soft_rst = 1'b0;
        @(negedge wb_clk);
        check("srst cyc", {30'h0, m_cyc, m_stb}, 32'h0);
        check("srst busy", {31'h0, busy}, 32'h0);
        repeat (3) tick();
        check("srst no rf_wr", rsp_q.size(), 0);
        check("srst err kept", {31'h0, err_flag}, 32'h1);

        // Command starved mid-way, then soft_rst: the half command is dropped.
        set_slave(0, 0, 0, 0, 32'h600DF00D);
        cmd_q.push_back(32'h8F000000);
        repeat (5) tick();
        check("starve busy", {31'h0, busy}, 32'h1);
        soft_rst = 1'b1;
        tick();
        soft_rst = 1'b0;
        @(negedge wb_clk);
        check("starve idle", {31'h0, busy}, 32'h0);
        tick();
        clear_logs();
        push_cmd(1'b0, 4'h5, 32'h500, 32'h0);
        wait_done("starve next done");
        check("starve next rsp", (rsp_q.size() > 0) ? rsp_q[0] : 32'hx, 32'h600DF00D);
        check_bus("starve next", 1'b0, 4'h5, 32'h500, 32'h0);

        // Asynchronous reset mid-cycle clears outputs without a clock edge.
        set_slave(0, 0, 0, 1, 32'h0);
        push_cmd(1'b0, 4'hF, 32'h600, 32'h0);
        wait_stb("areset stb seen");
        tick();
        wb_reset = 1'b1;
        #1;
        check("areset outputs", {29'h0, m_cyc, m_stb, busy}, 32'h0);
        check("areset err", {31'h0, err_flag}, 32'h0);
        tick();
        wb_reset = 1'b0;
        set_slave(0, 0, 0, 0, 32'h0);
        tick();

        // Randomized commands against a transaction-level expectation.
        exp_err_acc = 1'b0;
        for (int i = 0; i < 24; i++) begin
            r_we    = $urandom_range(0, 1);
            r_sel   = 4'($urandom_range(1, 15));
            r_adr   = $urandom & 32'hFFFF_FFFC;
            r_dat   = $urandom;
            r_rdata = $urandom;
            r_waits = $urandom_range(0, 3);
            r_rtys  = $urandom_range(0, 2);
            r_err   = ($urandom_range(0, 7) == 0);
            exp_err_acc = exp_err_acc | r_err;
            exp_rsp = r_err ? ERR_W : r_rdata;
            set_slave(r_waits, r_rtys, r_err, 0, r_rdata);
            clear_logs();
            push_cmd(r_we, r_sel, r_adr, r_dat);
            wait_done($sformatf("rnd%0d done", i));
            $display("TXN %0d we=%0d sel=%h adr=%h waits=%0d rtys=%0d err=%0d rsp_n=%0d",
                     i, r_we, r_sel, r_adr, r_waits, r_rtys, r_err, rsp_q.size());
            check($sformatf("rnd%0d rsp_n", i), rsp_q.size(), r_we ? 0 : 1);
            if (!r_we)
                check($sformatf("rnd%0d rsp", i), (rsp_q.size() > 0) ? rsp_q[0] : 32'hx, exp_rsp);
            check($sformatf("rnd%0d strobes", i), strobes, r_rtys + 1);
            check($sformatf("rnd%0d err_flag", i), {31'h0, err_flag}, {31'h0, exp_err_acc});
            check_bus($sformatf("rnd%0d", i), r_we, r_sel, r_adr, r_dat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
